// File: rtl/mbscore_alu_arbiter_pkg.sv
// Shared constants for the MBScore ALU arbiter: data/op widths, ALU op codes,
// the parked idle op code and the arbiter state encodings.
package mbscore_alu_arbiter_pkg;

  localparam int DATA_WIDTH   = 32;
  localparam int ALU_OP_WIDTH = 5;

  typedef logic [ALU_OP_WIDTH-1:0] alu_op_t;

  localparam alu_op_t ALU_OP_ADD  = 5'd0;
  localparam alu_op_t ALU_OP_ADDU = 5'd1;
  localparam alu_op_t ALU_OP_SUB  = 5'd2;
  localparam alu_op_t ALU_OP_SUBU = 5'd3;
  localparam alu_op_t ALU_OP_AND  = 5'd4;
  localparam alu_op_t ALU_OP_OR   = 5'd5;
  localparam alu_op_t ALU_OP_XOR  = 5'd6;
  localparam alu_op_t ALU_OP_NOR  = 5'd7;
  localparam alu_op_t ALU_OP_SLL  = 5'd8;
  localparam alu_op_t ALU_OP_SRL  = 5'd9;
  localparam alu_op_t ALU_OP_SRA  = 5'd10;
  localparam alu_op_t ALU_OP_EQ   = 5'd11;
  localparam alu_op_t ALU_OP_NE   = 5'd12;
  localparam alu_op_t ALU_OP_LT   = 5'd13;
  localparam alu_op_t ALU_OP_LTU  = 5'd14;
  // All-ones, outside the defined range, so parking here always forces an op change.
  localparam alu_op_t ALU_OP_IDLE = 5'd31;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_ISSUE,
    ARB_RESP
  } arb_state_t;

  function automatic logic op_defined(input alu_op_t op);
    return op <= ALU_OP_LTU;
  endfunction

  function automatic logic op_has_carry(input alu_op_t op);
    return (op == ALU_OP_ADD) || (op == ALU_OP_SUB);
  endfunction

endpackage

// File: rtl/mbscore_alu_arbiter_alu.sv
// MBScore ALU datapath: combinational result and carry/borrow per op code.
// Undefined codes, including the parked idle code, produce zero.
module mbscore_alu_arbiter_alu
  import mbscore_alu_arbiter_pkg::*;
(
  input  logic                    rst,
  input  logic [ALU_OP_WIDTH-1:0] op,
  input  logic [DATA_WIDTH-1:0]   a,
  input  logic [DATA_WIDTH-1:0]   b,
  output logic [DATA_WIDTH-1:0]   result,
  output logic                    cf
);

  localparam int SHW = $clog2(DATA_WIDTH);

  logic [DATA_WIDTH:0] sum_ext;
  logic [DATA_WIDTH:0] diff_ext;
  logic [SHW-1:0]      shamt;

  // The extra top bit of the difference is the borrow out.
  assign sum_ext  = {1'b0, a} + {1'b0, b};
  assign diff_ext = {1'b0, a} - {1'b0, b};
  assign shamt    = b[SHW-1:0];

  always_comb begin
    result = '0;
    cf     = 1'b0;
    if (!rst) begin
      case (op)
        ALU_OP_ADD: begin
          result = sum_ext[DATA_WIDTH-1:0];
          cf     = sum_ext[DATA_WIDTH];
        end
        ALU_OP_ADDU: result = sum_ext[DATA_WIDTH-1:0];
        ALU_OP_SUB: begin
          result = diff_ext[DATA_WIDTH-1:0];
          cf     = diff_ext[DATA_WIDTH];
        end
        ALU_OP_SUBU: result = diff_ext[DATA_WIDTH-1:0];
        ALU_OP_AND:  result = a & b;
        ALU_OP_OR:   result = a | b;
        ALU_OP_XOR:  result = a ^ b;
        ALU_OP_NOR:  result = ~(a | b);
        ALU_OP_SLL:  result = a << shamt;
        ALU_OP_SRL:  result = a >> shamt;
        ALU_OP_SRA:  result = $signed(a) >>> shamt;
        ALU_OP_EQ:   result = {{(DATA_WIDTH-1){1'b0}}, a == b};
        ALU_OP_NE:   result = {{(DATA_WIDTH-1){1'b0}}, a != b};
        ALU_OP_LT:   result = {{(DATA_WIDTH-1){1'b0}}, $signed(a) < $signed(b)};
        ALU_OP_LTU:  result = {{(DATA_WIDTH-1){1'b0}}, a < b};
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/mbscore_alu_arbiter.sv
// Round-robin arbiter sharing one MBScore ALU between NUM_REQ requesters,
// sequencing each operation through IDLE -> ISSUE -> RESP with valid/ready on both sides.
module mbscore_alu_arbiter
  import mbscore_alu_arbiter_pkg::*;
#(
  parameter int                    NUM_REQ = 2,
  parameter logic [ALU_OP_WIDTH-1:0] IDLE_OP = ALU_OP_IDLE
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [NUM_REQ-1:0]              req_valid,
  output logic [NUM_REQ-1:0]              req_ready,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]   req_a,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]   req_b,
  input  logic [NUM_REQ*ALU_OP_WIDTH-1:0] req_op,
  output logic [NUM_REQ-1:0]              resp_valid,
  input  logic [NUM_REQ-1:0]              resp_ready,
  output logic [DATA_WIDTH-1:0]           resp_data,
  output logic                            resp_cf,
  output logic                            resp_err,
  output logic                            busy
);

  localparam int PW = (NUM_REQ > 2) ? 2 : 1;

  arb_state_t                state;
  logic [PW-1:0]             rr_ptr;
  logic [PW-1:0]             owner;
  logic [DATA_WIDTH-1:0]     a_q;
  logic [DATA_WIDTH-1:0]     b_q;
  logic [ALU_OP_WIDTH-1:0]   alu_op_q;
  logic                      err_q;

  logic                      grant_found;
  logic [PW-1:0]             grant_idx;
  logic [PW-1:0]             cand;
  logic [ALU_OP_WIDTH-1:0]   grant_op;
  logic [DATA_WIDTH-1:0]     alu_result;
  logic                      alu_cf;

  function automatic logic [PW-1:0] wrap_add(input logic [PW-1:0] base, input int k);
    int s;
    s = int'(base) + k;
    if (s >= NUM_REQ) s = s - NUM_REQ;
    return PW'(s);
  endfunction

  // Round-robin pick: first valid requester searching from rr_ptr with wrap.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = wrap_add(rr_ptr, k);
      if (!grant_found && req_valid[cand]) begin
        grant_found = 1'b1;
        grant_idx   = cand;
      end
    end
  end

  assign grant_op  = req_op[int'(grant_idx)*ALU_OP_WIDTH +: ALU_OP_WIDTH];
  assign req_ready = (state == ARB_IDLE && !rst && grant_found) ? (NUM_REQ'(1) << grant_idx) : '0;
  assign busy      = (state != ARB_IDLE);

  mbscore_alu_arbiter_alu u_alu (
    .rst    (rst),
    .op     (alu_op_q),
    .a      (a_q),
    .b      (b_q),
    .result (alu_result),
    .cf     (alu_cf)
  );

  // The ALU op register is loaded at accept so the ALU has settled by the end of
  // ISSUE, when the response registers capture; it parks at IDLE_OP otherwise.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ARB_IDLE;
      rr_ptr     <= '0;
      owner      <= '0;
      a_q        <= '0;
      b_q        <= '0;
      alu_op_q   <= IDLE_OP;
      err_q      <= 1'b0;
      resp_valid <= '0;
      resp_data  <= '0;
      resp_cf    <= 1'b0;
      resp_err   <= 1'b0;
    end else begin
      case (state)
        ARB_IDLE: begin
          if (grant_found) begin
            owner    <= grant_idx;
            a_q      <= req_a[int'(grant_idx)*DATA_WIDTH +: DATA_WIDTH];
            b_q      <= req_b[int'(grant_idx)*DATA_WIDTH +: DATA_WIDTH];
            alu_op_q <= grant_op;
            err_q    <= !op_defined(grant_op);
            rr_ptr   <= wrap_add(grant_idx, 1);
            state    <= ARB_ISSUE;
          end
        end
        ARB_ISSUE: begin
          resp_valid <= NUM_REQ'(1) << owner;
          resp_err   <= err_q;
          resp_data  <= err_q ? '0 : alu_result;
          resp_cf    <= !err_q && op_has_carry(alu_op_q) && alu_cf;
          state      <= ARB_RESP;
        end
        ARB_RESP: begin
          if (resp_ready[owner]) begin
            resp_valid <= '0;
            resp_err   <= 1'b0;
            alu_op_q   <= IDLE_OP;
            state      <= ARB_IDLE;
          end
        end
        default: state <= ARB_IDLE;
      endcase
    end
  end

endmodule
